mult_seq: RTL and testbench

Sequential 32×32 signed multiplier controller built around one shared `csa_32` carry-select adder. It runs radix-2 Booth recoding over 32 iterations and issues one add, subtract or pass per cycle through the adder. It returns the low 32 bits of the product plus an overflow flag. It sits beside the ALU in the processor datapath and serves multiply instructions through a start/ready handshake.

---
 rtl/mult_pkg.sv | 12 +
 rtl/csa_32.sv | 21 ++
 rtl/mult_seq.sv | 105 ++++++++++
 tb/tb_mult_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and state encoding for the sequential Booth multiplier.
package mult_pkg;
  localparam int MULT_W    = 32;
  localparam int MULT_ITER = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;
endpackage

// File: rtl/csa_32.sv
// 32-bit carry-select adder: 16-bit low half ripples, high half is precomputed for both carries.
module csa_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        overflow
);
  logic [16:0] lo_sum;
  logic [15:0] hi_sum0;
  logic [15:0] hi_sum1;

  always_comb begin
    lo_sum  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
    hi_sum0 = a[31:16] + b[31:16];
    hi_sum1 = a[31:16] + b[31:16] + 16'd1;
    sum     = {(lo_sum[16] ? hi_sum1 : hi_sum0), lo_sum[15:0]};
    // Signed overflow: operands agree in sign but the result does not.
    overflow = (a[31] == b[31]) && (sum[31] != a[31]);
  end
endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 signed radix-2 Booth multiplier sharing one csa_32 across 32 iterations.
// state   | meaning
// IDLE    | waiting for start, operands captured on accept
// RUN     | one Booth add/sub/pass plus arithmetic shift per cycle
// DONE    | ready pulse, result registers valid; start accepted as in IDLE
module mult_seq
  import mult_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MULT_W-1:0] op_a,
  input  logic [MULT_W-1:0] op_b,
  output logic              busy,
  output logic              ready,
  output logic [MULT_W-1:0] product,
  output logic              overflow
);
  mult_state_t       state;
  logic [MULT_W-1:0] reg_a;
  logic [MULT_W-1:0] reg_q;
  logic [MULT_W-1:0] reg_m;
  logic              q_m1;
  logic [CNT_W-1:0]  cnt;

  logic [MULT_W-1:0] add_b;
  logic              add_cin;
  logic [MULT_W-1:0] add_sum;
  logic              add_ovf;
  logic [MULT_W-1:0] a_next;
  logic [MULT_W-1:0] q_next;

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({reg_q[0], q_m1})
      2'b01: add_b = reg_m;
      2'b10: begin
        add_b   = ~reg_m;
        add_cin = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  csa_32 u_csa (
    .a        (reg_a),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // The true 33-bit sign is sum[31]^ovf; shifting it in keeps M = 0x80000000 correct.
  always_comb begin
    a_next = {add_sum[MULT_W-1] ^ add_ovf, add_sum[MULT_W-1:1]};
    q_next = {add_sum[0], reg_q[MULT_W-1:1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      reg_a    <= '0;
      reg_q    <= '0;
      reg_m    <= '0;
      q_m1     <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          ready <= 1'b0;
          if (start) begin
            reg_m <= op_a;
            reg_q <= op_b;
            reg_a <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          reg_a <= a_next;
          reg_q <= q_next;
          q_m1  <= reg_q[0];
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MULT_ITER - 1)) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            ready    <= 1'b1;
            product  <= q_next;
            overflow <= (a_next != {MULT_W{q_next[MULT_W-1]}});
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Directed and random checks of mult_seq against a 64-bit arithmetic reference model.
module tb_mult_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        ready;
  logic [31:0] product;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  mult_seq dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .ready    (ready),
    .product  (product),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  // Reference: full signed product, low word plus "does not fit in 32 signed bits".
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] pv;
    logic [31:0] lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    lo = pv[31:0];
    return {(p != longint'($signed(lo))), lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one op, verify 32 busy cycles, ready on cycle 33, then result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic        run_ok;
    logic [32:0] exp;
    exp = ref_mul(a, b);
    @(negedge clock);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    run_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (!(busy === 1'b1 && ready === 1'b0)) run_ok = 1'b0;
      @(negedge clock);
    end
    check({tag, " busy32"}, {31'd0, run_ok}, 32'd1);
    check({tag, " ready"}, {31'd0, ready}, 32'd1);
    check({tag, " busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, " product"}, product, exp[31:0]);
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp[32]});
    @(negedge clock);
    check({tag, " ready_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [32:0] exp;
    logic        seen;
    int          cyc;
    logic [31:0] bb_a[3];
    logic [31:0] bb_b[3];

    repeat (3) @(negedge clock);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset product", product, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;

    // Directed cases, including the spec's literal expectations.
    run_op(32'd3, 32'd5, "3x5");
    check("3x5 literal", product, 32'h0000000F);
    run_op(-32'sd7, 32'd6, "-7x6");
    check("-7x6 literal", product, 32'hFFFFFFD6);
    run_op(32'h80000000, 32'd1, "min x 1");
    check("min x 1 ovf literal", {31'd0, overflow}, 32'd0);
    run_op(32'h80000000, 32'hFFFFFFFF, "min x -1");
    check("min x -1 ovf literal", {31'd0, overflow}, 32'd1);
    run_op(32'h00010000, 32'h00010000, "2^16 sq");
    check("2^16 sq literal", product, 32'd0);
    run_op(32'h80000000, 32'h80000000, "min x min");
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, "max x max");
    run_op(32'hFFFFFFFF, 32'h80000000, "-1 x min");
    run_op(32'h00000000, 32'h12345678, "0 x n");

    for (int k = 0; k < 10; k++) begin
      ra = $urandom;
      rb = (k < 5) ? $urandom : ($urandom_range(0, 65535) - 32768);
      run_op(ra, rb, $sformatf("rand%0d", k));
    end

    // Start during RUN must be ignored.
    @(negedge clock);
    start = 1'b1; op_a = 32'd2; op_b = 32'd2;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (cyc == 10) begin
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
      if (ready === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    check("ignore ready seen", {31'd0, seen}, 32'd1);
    check("ignore latency", cyc, 32'd33);
    check("ignore product", product, 32'd4);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (busy !== 1'b0 || ready !== 1'b0) seen = 1'b1;
    end
    check("ignore no relaunch", {31'd0, seen}, 32'd0);
    check("ignore product held", product, 32'd4);

    // Back-to-back with start held high; new operands presented in each DONE cycle.
    for (int k = 0; k < 3; k++) begin
      bb_a[k] = $urandom;
      bb_b[k] = $urandom;
    end
    @(negedge clock);
    start = 1'b1; op_a = bb_a[0]; op_b = bb_b[0];
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      exp = ref_mul(bb_a[k], bb_b[k]);
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
        @(negedge clock);
        cyc++;
        if (ready === 1'b1) seen = 1'b1;
      end
      check($sformatf("b2b%0d period", k), cyc, 32'd33);
      check($sformatf("b2b%0d product", k), product, exp[31:0]);
      check($sformatf("b2b%0d overflow", k), {31'd0, overflow}, {31'd0, exp[32]});
      if (k < 2) begin
        op_a = bb_a[k+1]; op_b = bb_b[k+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clock);
    check("b2b stop busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-RUN; product is nonzero beforehand.
    run_op(32'd7, 32'd7, "pre-reset");
    @(negedge clock);
    start = 1'b1; op_a = 32'd11; op_b = 32'd13;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    check("mid-run busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst ready", {31'd0, ready}, 32'd0);
    check("async rst product", product, 32'd0);
    check("async rst overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (busy !== 1'b0 || ready !== 1'b0) seen = 1'b1;
    end
    check("abandoned op", {31'd0, seen}, 32'd0);
    run_op(32'd4, -32'sd4, "4x-4");
    check("4x-4 literal", product, 32'hFFFFFFF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
